// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 channel mux: steps sel, samples f_in after a settle delay
// and publishes an 8-bit word with a one-cycle valid. Optional MUX_SCAN_CHG_EN adds a chg flag.
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int SCAN_DOWN     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f_in,
  output logic [2:0] sel,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       valid
`ifdef MUX_SCAN_CHG_EN
  ,
  output logic       chg
`endif
);

  localparam bit         DOWN      = (SCAN_DOWN != 0);
  localparam logic [2:0] FIRST     = DOWN ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST      = DOWN ? 3'd0 : 3'd7;
  localparam bit         NO_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [3:0] CNT_LAST  = NO_SETTLE ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] shadow;
  logic [7:0] word;

  // Completed word: everything captured so far plus the bit being sampled this edge.
  always_comb begin
    word      = shadow;
    word[sel] = f_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= FIRST;
      busy     <= 1'b0;
      valid    <= 1'b0;
      data_out <= 8'h00;
      cnt      <= 4'd0;
      shadow   <= 8'h00;
`ifdef MUX_SCAN_CHG_EN
      chg      <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef MUX_SCAN_CHG_EN
      chg   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state <= NO_SETTLE ? SAMPLE : SETTLE;
            busy  <= 1'b1;
            cnt   <= 4'd0;
          end
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          shadow[sel] <= f_in;
          if (sel != LAST) begin
            sel   <= DOWN ? sel - 3'd1 : sel + 3'd1;
            cnt   <= 4'd0;
            state <= NO_SETTLE ? SAMPLE : SETTLE;
          end else begin
            data_out <= word;
            valid    <= 1'b1;
            busy     <= 1'b0;
            sel      <= FIRST;
            state    <= IDLE;
`ifdef MUX_SCAN_CHG_EN
            chg      <= (word != data_out);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: four parameterizations, a cycle-offset reference model per
// instance compared every cycle, plus directed scenarios with literal expectations.
module tb_mux_scan_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      start;
  logic [3:0][7:0] iv;
  wire  [3:0]      f_a;
  logic [3:0][2:0] sel_a;
  logic [3:0]      busy_a, valid_a;
  logic [3:0][7:0] dout_a;
`ifdef MUX_SCAN_CHG_EN
  logic [3:0]      chg_a;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h want %0h at %0t", nm, g, a, e, $time);
    end
  endtask

  // g0: settle 1 up, g1: settle 3 up, g2: settle 1 down, g3: settle 0 up
  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int SC  = (g == 1) ? 3 : (g == 3) ? 0 : 1;
    localparam int SD  = (g == 2) ? 1 : 0;
    localparam int PER = SC + 1;

    assign f_a[g] = iv[g][sel_a[g]];

    mux_scan_ctrl #(.SETTLE_CYCLES(SC), .SCAN_DOWN(SD)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .f_in     (f_a[g]),
      .sel      (sel_a[g]),
      .busy     (busy_a[g]),
      .data_out (dout_a[g]),
      .valid    (valid_a[g])
`ifdef MUX_SCAN_CHG_EN
      ,
      .chg      (chg_a[g])
`endif
    );

    function automatic logic [2:0] ch(input int j);
      return (SD != 0) ? 3'(7 - j) : 3'(j);
    endfunction

    // Model: t = edges since the accepting edge; channel j is sampled at edge (j+1)*PER.
    bit         act;
    int         t;
    logic [7:0] mword, mdata;
    bit         mval, mchg;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        act = 0; t = 0; mword = 8'h00; mdata = 8'h00; mval = 0; mchg = 0;
      end else begin
        mval = 0; mchg = 0;
        if (act) begin
          if ((t + 1) % PER == 0) mword[ch(t / PER)] = iv[g][ch(t / PER)];
          t++;
          if (t == 8 * PER) begin
            act = 0; mval = 1; mchg = (mword != mdata); mdata = mword;
          end
        end else if (start[g]) begin
          act = 1; t = 0; mword = 8'h00;
        end
      end
    end

    always @(negedge clk) begin
      logic [2:0] esel;
      esel = act ? ch(t / PER) : ch(0);
      chk("sel",   g, sel_a[g],   esel);
      chk("busy",  g, busy_a[g],  act);
      chk("valid", g, valid_a[g], mval);
      chk("data",  g, dout_a[g],  mdata);
`ifdef MUX_SCAN_CHG_EN
      chk("chg",   g, chg_a[g],   mchg);
`endif
    end
  end

  // One-cycle start pulse, then count cycles to valid and busy cycles seen on the way.
  task automatic run_scan(input int g, input bit tog, output int k, output int bc);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    if (tog) iv[g][0] = ~iv[g][0];
    bc = int'(busy_a[g]);
    k  = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (tog && k == 1) iv[g][0] = ~iv[g][0];
      if (valid_a[g]) break;
      bc += int'(busy_a[g]);
      if (k >= 200) begin
        chk("timeout", g, 0, 1);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, bc, nv, v1, v2;
    rst = 1'b1; start = '0; iv = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", 0, dout_a[0], 8'h00);
    chk("rst_busy", 0, busy_a[0], 0);
    chk("rst_sel",  0, sel_a[0],  0);
    chk("rst_sel",  2, sel_a[2],  7);
    #2 rst = 1'b0;
    @(negedge clk);

    // basic scan, settle 1
    iv[0] = 8'hAA;
    run_scan(0, 0, k, bc);
    chk("lat16",  0, k,  16);
    chk("busy16", 0, bc, 16);
    chk("aa",     0, dout_a[0], 8'hAA);
    @(negedge clk);
    chk("vpulse", 0, valid_a[0], 0);
    chk("hold",   0, dout_a[0], 8'hAA);

    // settle 3 with a glitch on the selected input during the first settle cycle
    iv[1] = 8'h5C;
    run_scan(1, 1, k, bc);
    chk("lat32", 1, k, 32);
    chk("5c",    1, dout_a[1], 8'h5C);
    @(negedge clk);

    // start while busy is ignored
    iv[0] = 8'h96;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    nv = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start[0] = (i == 5);
      nv += int'(valid_a[0]);
    end
    chk("one_valid", 0, nv, 1);
    chk("96",        0, dout_a[0], 8'h96);

    // start held high: back-to-back scans
    start[0] = 1'b1; v1 = -1; v2 = -1;
    for (int i = 1; i <= 60 && v2 < 0; i++) begin
      @(negedge clk);
      if (valid_a[0]) begin
        if (v1 < 0) v1 = i; else v2 = i;
      end
    end
    start[0] = 1'b0;
    chk("b2b_gap", 0, v2 - v1, 17);
    repeat (40) @(negedge clk);

    // reset mid-scan
    iv[0] = 8'h55;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_sel",  0, sel_a[0],   0);
    chk("mid_busy", 0, busy_a[0],  0);
    chk("mid_data", 0, dout_a[0],  8'h00);
    chk("mid_val",  0, valid_a[0], 0);
    @(negedge clk);
    #2 rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      nv += int'(valid_a[0]);
    end
    chk("no_valid", 0, nv, 0);
    iv[0] = 8'hFF;
    run_scan(0, 0, k, bc);
    chk("ff", 0, dout_a[0], 8'hFF);
    @(negedge clk);

    // scan down: sel 7..0, two cycles per channel
    iv[2] = 8'h81;
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("dn_sel", 2, sel_a[2], 7 - i / 2);
      @(negedge clk);
    end
    chk("dn_valid", 2, valid_a[2], 1);
    chk("81",       2, dout_a[2],  8'h81);
    @(negedge clk);

    // zero settle: one cycle per channel
    iv[3] = 8'hC3;
    run_scan(3, 0, k, bc);
    chk("lat8", 3, k, 8);
    chk("c3",   3, dout_a[3], 8'hC3);
    @(negedge clk);

`ifdef MUX_SCAN_CHG_EN
    iv[0] = 8'h3C;
    run_scan(0, 0, k, bc);
    chk("chg1", 0, chg_a[0], 1);
    @(negedge clk);
    run_scan(0, 0, k, bc);
    chk("chg0", 0, chg_a[0], 0);
    @(negedge clk);
    iv[0] = 8'h00;
    run_scan(0, 0, k, bc);
    chk("chg1b", 0, chg_a[0], 1);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
